// File: rtl/pixel_axis_bridge.sv
// Purpose: buffers the ray-marcher's shaded pixel stream and re-emits it as an AXI4-Stream video master
//          (tuser = start of frame, tlast = end of line), tracking raster position to flag malformed frames.
// Latency: a pixel accepted into an empty bridge shows m_axis_tvalid after the following edge; 1 pixel/clk sustained.
// Backpressure: pix_ready is registered and drops once the FIFO plus the output register are full; no data is dropped.
//
// Optional feature macro: PIXEL_AXIS_REGEN_MARKERS_EN
//   defined   - tuser/tlast are regenerated from the tracker position at accept time (output framing always legal)
//   undefined - upstream pix_sof/pix_eol are stored in the FIFO and passed through unchanged
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   pix_data/valid/sof/eol   shaded pixel stream from the marcher
//   pix_ready                back-pressure to the marcher
//   m_axis_*                 AXI4-Stream video master (tdata, tvalid, tready, tuser, tlast)
//   err_clr                  synchronous clear of sticky error flags
//   err_sof, err_eol         sticky framing errors
//   frame_done               one-cycle pulse after the last pixel of a frame is accepted
module pixel_axis_bridge #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic        pix_ready,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    input  logic        err_clr,
    output logic        err_sof,
    output logic        err_eol,
    output logic        frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [PW-1:0] CNT_LAST = PW'(DEPTH - 1);

    // FIFO storage: {sof, eol, data}
    logic [25:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [25:0]   wr_dat;

    // raster tracker
    logic [XW-1:0] x;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y;
    logic [YW-1:0] y_nxt;
    logic          new_sof_err;
    logic          new_eol_err;
    logic          frame_end;

    // the extra pointer bit makes wr_ptr - rd_ptr the exact occupancy, 0..DEPTH
    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign push       = pix_valid & pix_ready;
    // refill the output register when it is empty or being consumed this cycle
    assign pop        = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

`ifdef PIXEL_AXIS_REGEN_MARKERS_EN
    assign wr_dat = {(x == '0) && (y == '0), (x == X_LAST), pix_data};
`else
    assign wr_dat = {pix_sof, pix_eol, pix_data};
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pix_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Ignores a same-cycle pop on purpose: conservative, so a write can never land on a full FIFO.
            pix_ready <= (count < CNT_LAST) || ((count == CNT_LAST) && !push);
        end
    end

    // output register: one word beyond the FIFO, held stable while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (pop) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[AW-1:0]];
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Position update for each accepted pixel. sof always resyncs to (1,0) after the
    // check; a line end is either an explicit eol or an implied one at the last column.
    always_comb begin
        x_nxt       = x;
        y_nxt       = y;
        new_sof_err = 1'b0;
        new_eol_err = 1'b0;
        frame_end   = 1'b0;
        if (push) begin
            if (pix_sof) begin
                new_sof_err = (x != '0) || (y != '0);
                x_nxt       = XW'(1);
                y_nxt       = '0;
            end else if (pix_eol || (x == X_LAST)) begin
                // flags both an early eol and a missing eol at the last column
                new_eol_err = !(pix_eol && (x == X_LAST));
                x_nxt       = '0;
                if (y == Y_LAST) begin
                    y_nxt     = '0;
                    frame_end = 1'b1;
                end else begin
                    y_nxt = y + YW'(1);
                end
            end else begin
                x_nxt = x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            err_eol    <= 1'b0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            frame_done <= frame_end;
            // a fresh error in the clearing cycle keeps the flag set
            err_sof    <= (err_sof & !err_clr) | new_sof_err;
            err_eol    <= (err_eol & !err_clr) | new_eol_err;
        end
    end

endmodule

// File: tb/tb_pixel_axis_bridge.sv
// Testbench for pixel_axis_bridge: input monitor feeds a raster-position reference model
// and an expected-beat queue; output monitor pops and compares every AXIS transfer.
// Directed phases (clean, back-pressure, framing errors, async reset) then random traffic.
module tb_pixel_axis_bridge;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic        pix_ready;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        err_clr = 1'b0;
    logic        err_sof;
    logic        err_eol;
    logic        frame_done;

    pixel_axis_bridge #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_ready     (pix_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .err_clr       (err_clr),
        .err_sof       (err_sof),
        .err_eol       (err_eol),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t acc_b;
    beat_t out_b;

    int checks = 0;
    int errors = 0;

    // reference model state: raster position and expected sticky flags
    int   mx = 0;
    int   my = 0;
    logic m_esof = 1'b0;
    logic m_eeol = 1'b0;

    int exp_fd = 0;
    int seen_fd = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int tuser_cnt = 0;
    int tlast_cnt = 0;
    int edge_cnt = 0;
    bit lat_arm = 1'b0;
    int first_acc = -1;
    int first_tv = -1;
    int rmode = 0;     // 0: tready=1, 1: tready=0, 2: random
    bit snd_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // tready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)      m_axis_tready = 1'b1;
            else if (rmode == 1) m_axis_tready = 1'b0;
            else                 m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Monitors: sampled at negedge, so a handshake seen here completes on the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            mx = 0;
            my = 0;
            m_esof = 1'b0;
            m_eeol = 1'b0;
        end else begin
            if (err_clr) begin
                m_esof = 1'b0;
                m_eeol = 1'b0;
            end
            if (pix_valid && pix_ready) begin
                acc_b.d = pix_data;
`ifdef PIXEL_AXIS_REGEN_MARKERS_EN
                acc_b.u = (mx == 0 && my == 0);
                acc_b.l = (mx == W - 1);
`else
                acc_b.u = pix_sof;
                acc_b.l = pix_eol;
`endif
                exp_q.push_back(acc_b);
                acc_cnt++;
                if (lat_arm && first_acc < 0) first_acc = edge_cnt + 1;
                if (pix_sof) begin
                    if (mx != 0 || my != 0) m_esof = 1'b1;
                    mx = 1;
                    my = 0;
                end else if (pix_eol || mx == W - 1) begin
                    if (mx != W - 1 || !pix_eol) m_eeol = 1'b1;
                    mx = 0;
                    my = my + 1;
                    if (my == H) begin
                        my = 0;
                        exp_fd++;
                    end
                end else begin
                    mx = mx + 1;
                end
            end
            if (frame_done) seen_fd++;
            if (m_axis_tvalid && lat_arm && first_tv < 0) first_tv = edge_cnt;
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                tuser_cnt += int'(m_axis_tuser);
                tlast_cnt += int'(m_axis_tlast);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h, required no output", m_axis_tdata);
                end else begin
                    out_b = exp_q.pop_front();
                    check($sformatf("beat%0d", out_cnt),
                          32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(out_b));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // called at posedge+1; returns at posedge+1 just after the pixel is accepted
    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int n;
        n = 0;
        pix_data  = d;
        pix_sof   = s;
        pix_eol   = e;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pix_ready 0 for pixel %h, required 1", d);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] base, input int max_gap);
        for (int i = 0; i < W * H; i++) begin
            send(base + 24'(i), i == 0, (i % W) == W - 1);
            if (max_gap > 0) tick($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 2000) begin
            tick(1);
            n++;
        end
        tick(2);
        check(name, exp_q.size(), 0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    int fd0, tu0, tl0, o0, a0, n;

    initial begin
        // reset state
        #2;
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_tuser", 32'(m_axis_tuser), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_err_sof", 32'(err_sof), 0);
        check("rst_err_eol", 32'(err_eol), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(pix_ready), 1);

        // clean frame, tready=1
        rmode = 0;
        tick(1);
        fd0 = seen_fd; tu0 = tuser_cnt; tl0 = tlast_cnt; o0 = out_cnt;
        lat_arm = 1'b1;
        send_frame(24'h000001, 0);
        drain("clean_drain");
        lat_arm = 1'b0;
        check("clean_latency", first_tv, first_acc + 1);
        check("clean_out_count", out_cnt - o0, 8);
        check("clean_tuser_count", tuser_cnt - tu0, 1);
        check("clean_tlast_count", tlast_cnt - tl0, 2);
        check("clean_frame_done", seen_fd - fd0, 1);
        check("clean_fd_model", seen_fd, exp_fd);
        check("clean_err_sof", 32'(err_sof), 0);
        check("clean_err_eol", 32'(err_eol), 0);

        // back-pressure: tready held low while pixels are offered
        rmode = 1;
        tick(2);
        a0 = acc_cnt; o0 = out_cnt; fd0 = seen_fd;
        snd_done = 1'b0;
        fork
            begin
                send_frame(24'h000001, 0);
                snd_done = 1'b1;
            end
        join_none
        tick(10);
        check("bp_tdata_hold_a", 32'(m_axis_tdata), 32'h000001);
        tick(10);
        check("bp_accepted", acc_cnt - a0, 5);
        check("bp_ready_low", 32'(pix_ready), 0);
        check("bp_tvalid", 32'(m_axis_tvalid), 1);
        check("bp_tdata_hold_b", 32'(m_axis_tdata), 32'h000001);
        rmode = 0;
        n = 0;
        while (!snd_done && n < 300) begin
            tick(1);
            n++;
        end
        check("bp_sender_done", 32'(snd_done), 1);
        drain("bp_drain");
        check("bp_out_count", out_cnt - o0, 8);
        check("bp_frame_done", seen_fd - fd0, 1);

        // misplaced eol on the 3rd pixel of line 0
        fd0 = seen_fd;
        send(24'h000101, 1'b1, 1'b0);
        send(24'h000102, 1'b0, 1'b0);
        send(24'h000103, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) send(24'h000104 + 24'(i), 1'b0, i == W - 1);
        drain("eol_drain");
        check("eol_err_eol", 32'(err_eol), 1);
        check("eol_err_model", 32'(err_eol), 32'(m_eeol));
        check("eol_err_sof", 32'(err_sof), 0);
        check("eol_frame_done", seen_fd - fd0, 1);
        tick(3);
        check("eol_sticky", 32'(err_eol), 1);
        clear_errors();
        check("eol_cleared", 32'(err_eol), 0);

        // spurious sof at (2,1): tracker resyncs to (1,0)
        fd0 = seen_fd;
        for (int i = 0; i < W; i++) send(24'h000201 + 24'(i), i == 0, i == W - 1);
        send(24'h000205, 1'b0, 1'b0);
        send(24'h000206, 1'b0, 1'b0);
        send(24'h000207, 1'b1, 1'b0);
        for (int i = 1; i < W; i++) send(24'h000210 + 24'(i), 1'b0, i == W - 1);
        for (int i = 0; i < W; i++) send(24'h000220 + 24'(i), 1'b0, i == W - 1);
        drain("sof_drain");
        check("sof_err_sof", 32'(err_sof), 1);
        check("sof_err_model", 32'(err_sof), 32'(m_esof));
        check("sof_err_eol", 32'(err_eol), 0);
        check("sof_frame_done", seen_fd - fd0, 1);
        clear_errors();
        check("sof_cleared", 32'(err_sof), 0);

        // async reset mid-frame after 3 accepted pixels
        rmode = 1;
        tick(2);
        send(24'h000301, 1'b1, 1'b0);
        send(24'h000302, 1'b0, 1'b0);
        send(24'h000303, 1'b0, 1'b0);
        tick(1);
        check("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("mid_rst_ready", 32'(pix_ready), 0);
        check("mid_rst_err_sof", 32'(err_sof), 0);
        check("mid_rst_err_eol", 32'(err_eol), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(pix_ready), 1);
        check("post_rst_tvalid", 32'(m_axis_tvalid), 0);
        rmode = 0;
        tick(1);
        fd0 = seen_fd; o0 = out_cnt;
        send_frame(24'h000401, 0);
        drain("post_rst_drain");
        check("post_rst_out_count", out_cnt - o0, 8);
        check("post_rst_frame_done", seen_fd - fd0, 1);
        check("post_rst_err_sof", 32'(err_sof), 0);
        check("post_rst_err_eol", 32'(err_eol), 0);

        // random data, random idle gaps, random tready
        rmode = 2;
        tick(1);
        fd0 = seen_fd; tu0 = tuser_cnt; tl0 = tlast_cnt; o0 = out_cnt;
        for (int f = 0; f < 6; f++) send_frame(24'($urandom), 2);
        rmode = 0;
        drain("rand_drain");
        check("rand_out_count", out_cnt - o0, 6 * W * H);
        check("rand_tuser_count", tuser_cnt - tu0, 6);
        check("rand_tlast_count", tlast_cnt - tl0, 6 * H);
        check("rand_frame_done", seen_fd - fd0, 6);
        check("rand_err_sof", 32'(err_sof), 0);
        check("rand_err_eol", 32'(err_eol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
